game_sequencer: RTL and testbench

//  Top-level play controller for Sky-Stacker; sequences the 60 s countdown timer.

---
 rtl/sky_pkg.sv | 22 ++
 rtl/tick_divider.sv | 43 ++++
 rtl/game_sequencer.sv | 155 +++++++++++++++
 tb/tb_game_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sky_pkg.sv
// Shared definitions for the Sky-Stacker play controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sky_pkg;

  // Top-level play state as shown on the state output; PAUSED is PLAY plus a paused flag.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READY = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  // Game-over cause bits; both may be set when both events land in one cycle.
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_TIME = 2'b01;
  localparam logic [1:0] CAUSE_FAIL = 2'b10;

  // System clock cycles per one-second tick on the board.
  localparam int TICK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/tick_divider.sv
// Divides the system clock into a one-cycle strobe every TICK_DIV enabled cycles.
// Latency: tick is combinational from the count register (high while count is at its last value).
// Backpressure: none; disabling holds the partial count, clr restarts it from zero.
import sky_pkg::*;

module tick_divider #(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_q;
  logic [CW-1:0] div_d;

  assign tick = en && (div_q == LAST);

  // Next count: clear wins, otherwise count and wrap only while enabled.
  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      div_d = (div_q == LAST) ? '0 : div_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Play controller: get-ready countdown, 1 Hz timer strobes, pause/restart, game-over latch.
// Latency: every output is registered and reacts one cycle after its cause.
// Backpressure: none; inputs are single-cycle pulses/levels acted on the cycle they arrive.
import sky_pkg::*;

module game_sequencer #(
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int READY_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       time_up,
  input  logic       stack_fail,
  output logic       timer_tick,
  output logic       timer_clr,
  output logic       timer_pause,
  output logic       game_active,
  output logic [2:0] ready_cnt,
  output logic [1:0] state,
  output logic       paused,
  output logic [1:0] over_cause
);

  localparam logic [2:0] READY_LOAD = 3'(READY_SECS);

  state_e     state_q, state_d;
  logic       paused_q, paused_d;
  logic [2:0] ready_q, ready_d;
  logic [1:0] cause_q, cause_d;
  logic       clr_q, clr_d;
  logic       tick_q, tick_d;
  logic       tpause_q, tpause_d;
  logic       active_q, active_d;

  logic       div_en;
  logic       div_clr;
  logic       sec_tick;
  logic       go_ready;

  // The second counter only runs while counting down or actively playing;
  // while paused it holds so the partial second survives the pause.
  assign div_en = (state_q == ST_READY) || ((state_q == ST_PLAY) && !paused_q);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (sec_tick)
  );

  // Next-state and registered-output decode; game end beats start beats pause.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    ready_d  = ready_q;
    cause_d  = cause_q;
    clr_d    = 1'b0;
    tick_d   = 1'b0;
    div_clr  = 1'b0;
    go_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_p) go_ready = 1'b1;
      end
      ST_READY: begin
        if (sec_tick) begin
          if (ready_q > 3'd1) begin
            ready_d = ready_q - 3'd1;
          end else begin
            state_d  = ST_PLAY;
            paused_d = 1'b0;
            ready_d  = 3'd0;
          end
        end
      end
      ST_PLAY: begin
        if (!paused_q) begin
          if (time_up || stack_fail) begin
            // A tick landing on the game-end cycle is swallowed.
            state_d = ST_OVER;
            cause_d = (time_up ? CAUSE_TIME : CAUSE_NONE) |
                      (stack_fail ? CAUSE_FAIL : CAUSE_NONE);
          end else begin
            tick_d = sec_tick;
            if (pause_p) paused_d = 1'b1;
          end
        end else begin
          if (start_p) begin
            go_ready = 1'b1;
          end else if (pause_p) begin
            paused_d = 1'b0;
          end
        end
      end
      ST_OVER: begin
        if (start_p) go_ready = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Common (re)start path: reload the timer and restart the countdown from a whole second.
    if (go_ready) begin
      state_d  = ST_READY;
      paused_d = 1'b0;
      ready_d  = READY_LOAD;
      cause_d  = CAUSE_NONE;
      clr_d    = 1'b1;
      div_clr  = 1'b1;
    end

    active_d = (state_d == ST_PLAY) && !paused_d;
    tpause_d = !active_d;
  end

  // State and output registers; reset parks the game in IDLE with the timer frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      paused_q <= 1'b0;
      ready_q  <= 3'd0;
      cause_q  <= CAUSE_NONE;
      clr_q    <= 1'b0;
      tick_q   <= 1'b0;
      tpause_q <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      ready_q  <= ready_d;
      cause_q  <= cause_d;
      clr_q    <= clr_d;
      tick_q   <= tick_d;
      tpause_q <= tpause_d;
      active_q <= active_d;
    end
  end

  assign timer_tick  = tick_q;
  assign timer_clr   = clr_q;
  assign timer_pause = tpause_q;
  assign game_active = active_q;
  assign ready_cnt   = ready_q;
  assign state       = state_q;
  assign paused      = paused_q;
  assign over_cause  = cause_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer with TICK_DIV=4, READY_SECS=3.
// Expected status snapshots and timer pulses are queued by the stimulus with
// hand-computed cycle numbers; a negedge monitor pops and compares them.
module tb_game_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_p, pause_p, time_up, stack_fail;
  logic       timer_tick, timer_clr, timer_pause, game_active, paused;
  logic [2:0] ready_cnt;
  logic [1:0] state, over_cause;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       p;
    logic       ga;
    logic       tp;
    logic [2:0] rc;
    logic [1:0] oc;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t v;
  } snap_e;

  typedef struct {
    int cyc;
    bit is_clr;
  } pulse_e;

  snap_e  snap_q[$];
  pulse_e pulse_q[$];

  game_sequencer #(
    .TICK_DIV   (4),
    .READY_SECS (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_p     (start_p),
    .pause_p     (pause_p),
    .time_up     (time_up),
    .stack_fail  (stack_fail),
    .timer_tick  (timer_tick),
    .timer_clr   (timer_clr),
    .timer_pause (timer_pause),
    .game_active (game_active),
    .ready_cnt   (ready_cnt),
    .state       (state),
    .paused      (paused),
    .over_cause  (over_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk(input logic [1:0] st, input logic p, input logic ga,
                               input logic tp, input logic [2:0] rc, input logic [1:0] oc);
    snap_t s;
    s = '{st: st, p: p, ga: ga, tp: tp, rc: rc, oc: oc};
    return s;
  endfunction

  task automatic exp_snap(input int c, input snap_t v);
    snap_e e;
    e.cyc = c;
    e.v   = v;
    snap_q.push_back(e);
  endtask

  task automatic exp_pulse(input int c, input bit is_clr);
    pulse_e e;
    e.cyc    = c;
    e.is_clr = is_clr;
    pulse_q.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_pulse(input bit is_clr);
    pulse_e e;
    checks++;
    if (pulse_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cyc=%0d actual=pulse required=none",
               is_clr ? "timer_clr" : "timer_tick", cyc);
    end else begin
      e = pulse_q.pop_front();
      if (e.cyc != cyc || e.is_clr != is_clr) begin
        errors++;
        $display("FAIL pulse actual=%s@%0d required=%s@%0d",
                 is_clr ? "clr" : "tick", cyc, e.is_clr ? "clr" : "tick", e.cyc);
      end
    end
  endtask

  // Monitor: compares status snapshots due this cycle and every timer pulse the DUT emits.
  always @(negedge clk) begin
    snap_t  act;
    snap_e  se;
    pulse_e pe;
    act = mk(state, paused, game_active, timer_pause, ready_cnt, over_cause);
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      se = snap_q.pop_front();
      checks++;
      if (se.cyc != cyc || act !== se.v) begin
        errors++;
        $display("FAIL snap cyc=%0d actual st=%b p=%b ga=%b tp=%b rc=%0d oc=%b required st=%b p=%b ga=%b tp=%b rc=%0d oc=%b (due %0d)",
                 cyc, act.st, act.p, act.ga, act.tp, act.rc, act.oc,
                 se.v.st, se.v.p, se.v.ga, se.v.tp, se.v.rc, se.v.oc, se.cyc);
      end
    end
    while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
      pe = pulse_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_%s cyc=%0d actual=none required=pulse",
               pe.is_clr ? "timer_clr" : "timer_tick", pe.cyc);
    end
    if (timer_clr !== 1'b0)  check_pulse(1'b1);
    if (timer_tick !== 1'b0) check_pulse(1'b0);
  end

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t s_idle, s_play, s_paused;
    s_idle   = mk(2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00);
    s_play   = mk(2'b10, 1'b0, 1'b1, 1'b0, 3'd0, 2'b00);
    s_paused = mk(2'b10, 1'b1, 1'b0, 1'b1, 3'd0, 2'b00);

    rst_n = 1'b0; start_p = 1'b0; pause_p = 1'b0; time_up = 1'b0; stack_fail = 1'b0;
    exp_snap(1, s_idle);
    at(2);
    rst_n = 1'b1;
    exp_snap(3, s_idle);

    // Start: timer_clr once, countdown 3-2-1 at 4 clk per digit, then PLAYING.
    at(4);
    start_p = 1'b1;
    exp_pulse(5, 1'b1);
    exp_snap(5,  mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd3, 2'b00));
    exp_snap(8,  mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd3, 2'b00));
    exp_snap(9,  mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd2, 2'b00));
    exp_snap(13, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd1, 2'b00));
    exp_snap(16, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd1, 2'b00));
    exp_snap(17, s_play);
    // Three seconds of play: ticks 4 clk apart.
    exp_pulse(21, 1'b0);
    exp_pulse(25, 1'b0);
    exp_pulse(29, 1'b0);
    exp_snap(29, s_play);
    at(5);
    start_p = 1'b0;

    // Pause with two of four counts consumed; no ticks for 20 clk; resume finishes the second.
    at(30);
    pause_p = 1'b1;
    exp_snap(31, s_paused);
    exp_snap(50, s_paused);
    at(31);
    pause_p = 1'b0;
    at(51);
    pause_p = 1'b1;
    exp_snap(52, s_play);
    exp_pulse(54, 1'b0);
    at(52);
    pause_p = 1'b0;

    // time_up and stack_fail together on a tick cycle: OVER, cause 11, tick swallowed.
    at(57);
    time_up = 1'b1;
    stack_fail = 1'b1;
    exp_snap(58, mk(2'b11, 1'b0, 1'b0, 1'b1, 3'd0, 2'b11));
    exp_snap(60, mk(2'b11, 1'b0, 1'b0, 1'b1, 3'd0, 2'b11));
    at(58);
    stack_fail = 1'b0;

    // Restart from OVER; pause_p and start_p during READY change nothing.
    at(61);
    start_p = 1'b1;
    exp_pulse(62, 1'b1);
    exp_snap(62, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd3, 2'b00));
    exp_snap(64, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd3, 2'b00));
    exp_snap(66, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd2, 2'b00));
    exp_snap(70, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd1, 2'b00));
    exp_snap(74, s_play);
    at(62);
    start_p = 1'b0;
    time_up = 1'b0;
    at(63);
    pause_p = 1'b1;
    at(64);
    pause_p = 1'b0;
    start_p = 1'b1;
    at(65);
    start_p = 1'b0;

    // Asynchronous reset just after a clock edge mid-PLAYING.
    at(76);
    exp_snap(77, s_idle);
    @(posedge clk);
    #1 rst_n = 1'b0;
    at(78);
    rst_n = 1'b1;
    exp_snap(80, s_idle);
    exp_snap(90, s_idle);

    // Fresh game, then a lone stack_fail ends it with cause 10.
    at(92);
    start_p = 1'b1;
    exp_pulse(93, 1'b1);
    exp_snap(93, mk(2'b01, 1'b0, 1'b0, 1'b1, 3'd3, 2'b00));
    exp_snap(105, s_play);
    exp_snap(107, mk(2'b11, 1'b0, 1'b0, 1'b1, 3'd0, 2'b10));
    at(93);
    start_p = 1'b0;
    at(106);
    stack_fail = 1'b1;
    at(107);
    stack_fail = 1'b0;

    at(112);
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL pulse_leftover actual=%0d required=0", pulse_q.size());
    end
    checks++;
    if (snap_q.size() != 0) begin
      errors++;
      $display("FAIL snap_leftover actual=%0d required=0", snap_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
